// File: rtl/online_otf_converter_pkg.sv
// Shared online-arithmetic definitions: signed-digit encoding, digit decode,
// converter FSM states and per-CCM digit-count derivation.
package online_otf_converter_pkg;

  localparam int unsigned PosBit = 1;
  localparam int unsigned NegBit = 0;

  typedef enum logic [1:0] {
    DigZero = 2'b00,
    DigPos  = 2'b01,
    DigNeg  = 2'b10
  } digit_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StConv = 2'b01,
    StDone = 2'b10
  } otf_state_e;

  // Code 11 is a legal redundant zero.
  function automatic digit_e digit_decode(input logic [1:0] pair);
    digit_e d;
    d = DigZero;
    if (pair[PosBit] && !pair[NegBit]) d = DigPos;
    if (!pair[PosBit] && pair[NegBit]) d = DigNeg;
    return d;
  endfunction

  function automatic int unsigned ccm_ndig(input int unsigned stage, input int unsigned s1);
    return (2 * (stage + s1 + 1)) / 2;
  endfunction

endpackage

// File: rtl/online_otf_step.sv
// One on-the-fly conversion step: appends digit d to the Q/QM pair using only
// shifts and concatenation, keeping QM = Q - 1.
module online_otf_step
  import online_otf_converter_pkg::*;
#(
  parameter int unsigned OW = 12
) (
  input  digit_e        d_i,
  input  logic [OW-1:0] q_i,
  input  logic [OW-1:0] qm_i,
  output logic [OW-1:0] q_o,
  output logic [OW-1:0] qm_o
);

  logic [OW-1:0] q_sh;
  logic [OW-1:0] qm_sh;

  assign q_sh  = q_i << 1;
  assign qm_sh = qm_i << 1;

  always_comb begin
    q_o  = q_sh;
    qm_o = qm_sh | OW'(1);
    unique case (d_i)
      DigPos: begin
        q_o  = q_sh | OW'(1);
        qm_o = q_sh;
      end
      DigNeg: begin
        q_o  = qm_sh | OW'(1);
        qm_o = qm_sh;
      end
      default: begin
        q_o  = q_sh;
        qm_o = qm_sh | OW'(1);
      end
    endcase
  end

endmodule

// File: rtl/online_otf_converter.sv
// MSD-first signed-digit to two's-complement converter with valid/ready
// handshakes; one digit per clock, no overlap between words.
module online_otf_converter
  import online_otf_converter_pkg::*;
#(
  parameter int unsigned NDIG = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*NDIG-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NDIG:0]     out_data
);

  localparam int unsigned OW   = NDIG + 1;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NDIG - 1);

  otf_state_e        state_q, state_d;
  logic [2*NDIG-1:0] sr_q, sr_d;
  logic [OW-1:0]     q_q, q_d;
  logic [OW-1:0]     qm_q, qm_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]     out_q, out_d;
  logic [OW-1:0]     q_next, qm_next;
  digit_e            top_digit;

  assign top_digit = digit_decode(sr_q[2*NDIG-1 -: 2]);

  online_otf_step #(
    .OW(OW)
  ) u_step (
    .d_i (top_digit),
    .q_i (q_q),
    .qm_i(qm_q),
    .q_o (q_next),
    .qm_o(qm_next)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sr_d    = in_data;
          q_d     = '0;
          qm_d    = '1;
          cnt_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        sr_d  = sr_q << 2;
        q_d   = q_next;
        qm_d  = qm_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          out_d   = q_next;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      q_q     <= '0;
      qm_q    <= '1;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Handshake flags decode straight from state so reset clears them at once.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = out_q;

endmodule

// File: tb/tb_online_otf_converter.sv
// Directed and random checks of the signed-digit to two's-complement converter.
module tb_online_otf_converter;

  localparam int NDIG = 11;
  localparam int OW   = NDIG + 1;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2*NDIG-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;

  int n_cmp = 0;
  int n_bad = 0;

  online_otf_converter #(
    .NDIG(NDIG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain positional-weight sum of the digits, independent of the OTF recurrence.
  function automatic logic [OW-1:0] model(input logic [2*NDIG-1:0] w);
    int s;
    s = 0;
    for (int j = 1; j <= NDIG; j++) begin
      s = s * 2 + int'(w[2*(NDIG-j)+1]) - int'(w[2*(NDIG-j)]);
    end
    return OW'(s);
  endfunction

  // Accept a word, wait for the result, optionally stall, then drain it.
  task automatic convert(input string tag, input logic [2*NDIG-1:0] w,
                         input logic [OW-1:0] exp, input int stall);
    int lat;
    logic rdy_seen;
    logic [OW-1:0] held;
    logic stable;
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 20) begin
      if (in_ready) rdy_seen = 1'b1;
      in_data = ~in_data;
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(NDIG));
    check({tag, "_in_ready_busy"}, 32'(rdy_seen | in_ready), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    held = out_data;
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      in_valid = i[0];
      in_data  = ~w;
      tick();
      if (!out_valid || in_ready || out_data !== held) stable = 1'b0;
    end
    in_valid = 1'b0;
    if (stall > 0) check({tag, "_stall_stable"}, 32'(stable), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  logic [2*NDIG-1:0] rw;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    convert("zero", 22'h000000, 12'h000, 0);
    convert("d1_pos", 22'h200000, 12'h400, 0);
    convert("d1_neg", 22'h100000, 12'hC00, 0);
    convert("d1p_d2n", 22'h240000, 12'h200, 0);
    convert("d11_neg", 22'h000001, 12'hFFF, 0);
    convert("all_pos", 22'h2AAAAA, 12'h7FF, 0);
    convert("all_neg", 22'h155555, 12'h801, 0);
    convert("all_11", 22'h3FFFFF, 12'h000, 0);
    convert("stall5", 22'h2AAAAA, 12'h7FF, 5);
    convert("after_stall", 22'h240000, 12'h200, 0);

    // out_ready in IDLE must not disturb anything.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_out_ready", {30'd0, out_valid, in_ready}, 32'b01);

    // Abort during CONV at cnt=5.
    in_data  = 22'h155555;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    check("abort_conv_flags", {30'd0, out_valid, in_ready}, 32'b01);
    tick();
    rst_n = 1'b1;
    tick();
    convert("post_abort_conv", 22'h200000, 12'h400, 0);

    // Abort in DONE: out_valid must drop without a clock edge.
    in_data  = 22'h2AAAAA;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < NDIG; i++) tick();
    check("pre_abort_done_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_done_flags", {30'd0, out_valid, in_ready}, 32'b01);
    check("abort_done_data", 32'(out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    convert("post_abort_done", 22'h100000, 12'hC00, 0);

    for (int k = 0; k < 300; k++) begin
      rw = 22'($urandom);
      convert("rand", rw, model(rw), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
